// File: rtl/game_timer_ctrl.sv
// Sudoku game timer sequencer: owns the game state, counts BCD seconds from the
// 1 Hz level, flags a loss at the time limit and keeps the best winning time.
module game_timer_ctrl #(
    parameter logic [3:0] LIMIT_H = 4'd3,
    parameter logic [3:0] LIMIT_T = 4'd0,
    parameter logic [3:0] LIMIT_U = 4'd0
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick_lvl,
    input  logic       start_p,
    input  logic       pause_p,
    input  logic       win_flag,
    output logic [2:0] state,
    output logic [3:0] sec_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_h,
    output logic [3:0] best_u,
    output logic [3:0] best_t,
    output logic [3:0] best_h,
    output logic       best_valid,
    output logic       lose_flag,
    output logic       new_record
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_WIN   = 3'd3,
        S_LOSE  = 3'd4
    } state_t;

    localparam logic [11:0] LIMIT    = {LIMIT_H, LIMIT_T, LIMIT_U};
    localparam logic [11:0] BCD_MAX  = 12'h999;
    localparam logic [11:0] BCD_ZERO = 12'h000;

    state_t      state_q, state_d;
    logic [11:0] sec_q, sec_d;
    logic [11:0] best_q, best_d;
    logic        best_valid_q, best_valid_d;
    logic        new_record_q, new_record_d;
    logic        tick_prev_q;

    logic        tick_edge;
    logic [11:0] sec_inc;
    logic        limit_hit;

    // Three-digit BCD increment, saturating at 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] h, t, u;
        {h, t, u} = v;
        if (v == BCD_MAX) begin
            return v;
        end
        if (u == 4'd9) begin
            u = 4'd0;
            if (t == 4'd9) begin
                t = 4'd0;
                h = h + 4'd1;
            end else begin
                t = t + 4'd1;
            end
        end else begin
            u = u + 4'd1;
        end
        return {h, t, u};
    endfunction

    // Magnitude compare of two BCD times, most significant digit first.
    function automatic logic bcd_less(input logic [11:0] a, input logic [11:0] b);
        if (a[11:8] != b[11:8]) begin
            return a[11:8] < b[11:8];
        end
        if (a[7:4] != b[7:4]) begin
            return a[7:4] < b[7:4];
        end
        return a[3:0] < b[3:0];
    endfunction

    assign tick_edge = tick_lvl & ~tick_prev_q;
    assign sec_inc   = bcd_inc(sec_q);
    // A zero limit can never be reached by incrementing, so it trips on the first tick.
    assign limit_hit = (sec_inc == LIMIT) || (LIMIT == BCD_ZERO);

    always_comb begin
        state_d      = state_q;
        sec_d        = sec_q;
        best_d       = best_q;
        best_valid_d = best_valid_q;
        new_record_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_p) begin
                    state_d = S_RUN;
                    sec_d   = BCD_ZERO;
                end
            end
            S_RUN: begin
                if (win_flag) begin
                    state_d = S_WIN;
                    if (!best_valid_q || bcd_less(sec_q, best_q)) begin
                        best_d       = sec_q;
                        best_valid_d = 1'b1;
                        new_record_d = 1'b1;
                    end
                end else if (tick_edge) begin
                    if (limit_hit) begin
                        sec_d   = LIMIT;
                        state_d = S_LOSE;
                    end else begin
                        sec_d = sec_inc;
                        if (pause_p) begin
                            state_d = S_PAUSE;
                        end
                    end
                end else if (pause_p) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (pause_p) begin
                    state_d = S_RUN;
                end
            end
            S_WIN, S_LOSE: begin
                if (start_p) begin
                    state_d = S_RUN;
                    sec_d   = BCD_ZERO;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= S_IDLE;
            sec_q        <= BCD_ZERO;
            best_q       <= BCD_MAX;
            best_valid_q <= 1'b0;
            new_record_q <= 1'b0;
            tick_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sec_q        <= sec_d;
            best_q       <= best_d;
            best_valid_q <= best_valid_d;
            new_record_q <= new_record_d;
            tick_prev_q  <= tick_lvl;
        end
    end

    assign state      = state_q;
    assign {sec_h, sec_t, sec_u}    = sec_q;
    assign {best_h, best_t, best_u} = best_q;
    assign best_valid = best_valid_q;
    assign lose_flag  = (state_q == S_LOSE);
    assign new_record = new_record_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: two instances (default limit 300 and limit 005)
// checked every cycle against an integer model, plus literal checkpoints.
module tb_game_timer_ctrl;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic tick_lvl = 1'b0, start_p = 1'b0, pause_p = 1'b0, win_flag = 1'b0;

    logic [2:0] st0, st1;
    logic [3:0] su0, stn0, sh0, bu0, bt0, bh0;
    logic [3:0] su1, stn1, sh1, bu1, bt1, bh1;
    logic       bv0, lf0, nr0, bv1, lf1, nr1;

    always #5 clk = ~clk;

    game_timer_ctrl dut (
        .clk(clk), .clr(clr), .tick_lvl(tick_lvl), .start_p(start_p),
        .pause_p(pause_p), .win_flag(win_flag), .state(st0),
        .sec_u(su0), .sec_t(stn0), .sec_h(sh0),
        .best_u(bu0), .best_t(bt0), .best_h(bh0),
        .best_valid(bv0), .lose_flag(lf0), .new_record(nr0)
    );

    game_timer_ctrl #(.LIMIT_H(4'd0), .LIMIT_T(4'd0), .LIMIT_U(4'd5)) dut5 (
        .clk(clk), .clr(clr), .tick_lvl(tick_lvl), .start_p(start_p),
        .pause_p(pause_p), .win_flag(win_flag), .state(st1),
        .sec_u(su1), .sec_t(stn1), .sec_h(sh1),
        .best_u(bu1), .best_t(bt1), .best_h(bh1),
        .best_valid(bv1), .lose_flag(lf1), .new_record(nr1)
    );

    int n_cmp = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    int m_state [2];
    int m_sec   [2];
    int m_best  [2];
    bit m_bv    [2];
    bit m_nr    [2];
    bit m_prev  [2];
    int lim     [2] = '{300, 5};

    function automatic int to_int(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
        return int'(h) * 100 + int'(t) * 10 + int'(u);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Game rules expressed on plain integer seconds.
    task automatic model_step(input int i);
        bit edge_seen;
        int nxt;
        edge_seen = tick_lvl && !m_prev[i];
        m_prev[i] = tick_lvl;
        m_nr[i]   = 1'b0;
        case (m_state[i])
            0: if (start_p) begin m_state[i] = 1; m_sec[i] = 0; end
            1: begin
                if (win_flag) begin
                    m_state[i] = 3;
                    if (!m_bv[i] || m_sec[i] < m_best[i]) begin
                        m_best[i] = m_sec[i];
                        m_bv[i]   = 1'b1;
                        m_nr[i]   = 1'b1;
                    end
                end else if (edge_seen) begin
                    nxt = (m_sec[i] >= 999) ? 999 : m_sec[i] + 1;
                    if (nxt == lim[i] || lim[i] == 0) begin
                        m_sec[i]   = lim[i];
                        m_state[i] = 4;
                    end else begin
                        m_sec[i] = nxt;
                        if (pause_p) m_state[i] = 2;
                    end
                end else if (pause_p) begin
                    m_state[i] = 2;
                end
            end
            2: if (pause_p) m_state[i] = 1;
            default: if (start_p) begin m_state[i] = 1; m_sec[i] = 0; end
        endcase
    endtask

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 2; i++) begin
                m_state[i] = 0; m_sec[i] = 0; m_best[i] = 999;
                m_bv[i] = 1'b0; m_nr[i] = 1'b0; m_prev[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    task automatic cmp_inst(input int i, input logic [2:0] st, input int sec, input int best,
                            input logic bv, input logic lf, input logic nr);
        check($sformatf("c%0d_state", i), int'(st), m_state[i]);
        check($sformatf("c%0d_sec", i), sec, m_sec[i]);
        check($sformatf("c%0d_best", i), best, m_best[i]);
        check($sformatf("c%0d_best_valid", i), int'(bv), int'(m_bv[i]));
        check($sformatf("c%0d_lose_flag", i), int'(lf), (m_state[i] == 4) ? 1 : 0);
        check($sformatf("c%0d_new_record", i), int'(nr), int'(m_nr[i]));
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_inst(0, st0, to_int(sh0, stn0, su0), to_int(bh0, bt0, bu0), bv0, lf0, nr0);
            cmp_inst(1, st1, to_int(sh1, stn1, su1), to_int(bh1, bt1, bu1), bv1, lf1, nr1);
        end
    end

    task automatic step(input bit tk, input bit st, input bit ps, input bit wn);
        tick_lvl = tk; start_p = st; pause_p = ps; win_flag = wn;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            step(1, 0, 0, 0);
            step(0, 0, 0, 0);
        end
    endtask

    task automatic do_reset();
        tick_lvl = 0; start_p = 0; pause_p = 0; win_flag = 0;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        cmp_en = 1'b1;
        check("rst_state", int'(st0), 0);
        check("rst_best", to_int(bh0, bt0, bu0), 999);
        check("rst_bv", int'(bv0), 0);

        // Start, tick latency, then a dozen seconds
        step(0, 1, 0, 0);
        check("t1_start_state", int'(st0), 1);
        tick_lvl = 1'b1; start_p = 1'b0;
        #2;
        check("t1_pre_edge", to_int(sh0, stn0, su0), 0);
        @(posedge clk);
        #1;
        check("t1_post_edge", to_int(sh0, stn0, su0), 1);
        step(0, 0, 0, 0);
        ticks(11);
        check("t1_sec", to_int(sh0, stn0, su0), 12);
        check("t1_state", int'(st0), 1);

        // BCD carries and pause
        do_reset();
        step(0, 1, 0, 0);
        ticks(9);
        check("t2_009", to_int(sh0, stn0, su0), 9);
        ticks(1);
        check("t2_010", to_int(sh0, stn0, su0), 10);
        ticks(89);
        check("t2_099", to_int(sh0, stn0, su0), 99);
        ticks(1);
        check("t2_100", to_int(sh0, stn0, su0), 100);
        step(0, 0, 1, 0);
        ticks(5);
        check("t2_paused_sec", to_int(sh0, stn0, su0), 100);
        check("t2_paused_state", int'(st0), 2);
        step(0, 0, 1, 0);
        check("t2_resume_state", int'(st0), 1);

        // Limit 005 on the second instance
        do_reset();
        step(0, 1, 0, 0);
        ticks(5);
        check("t3_sec", to_int(sh1, stn1, su1), 5);
        check("t3_state", int'(st1), 4);
        check("t3_lose", int'(lf1), 1);
        ticks(2);
        check("t3_hold", to_int(sh1, stn1, su1), 5);
        step(0, 1, 0, 0);
        check("t3_restart_state", int'(st1), 1);
        check("t3_restart_sec", to_int(sh1, stn1, su1), 0);
        check("t3_restart_lose", int'(lf1), 0);

        // Best-time tracking across three games
        do_reset();
        step(0, 1, 0, 0);
        ticks(42);
        step(0, 0, 0, 1);
        check("t4_win_state", int'(st0), 3);
        check("t4_best1", to_int(bh0, bt0, bu0), 42);
        check("t4_bv1", int'(bv0), 1);
        check("t4_nr1", int'(nr0), 1);
        step(0, 0, 0, 0);
        check("t4_nr1_drop", int'(nr0), 0);
        check("t4_hold", to_int(sh0, stn0, su0), 42);
        step(0, 1, 0, 0);
        ticks(50);
        step(0, 0, 0, 1);
        check("t4_best2", to_int(bh0, bt0, bu0), 42);
        check("t4_nr2", int'(nr0), 0);
        step(0, 1, 0, 0);
        ticks(39);
        step(0, 0, 0, 1);
        check("t4_best3", to_int(bh0, bt0, bu0), 39);
        check("t4_nr3", int'(nr0), 1);
        step(0, 0, 0, 0);

        // Simultaneous events
        do_reset();
        step(0, 1, 0, 0);
        ticks(7);
        step(1, 0, 0, 1);
        check("t5_win_tick_state", int'(st0), 3);
        check("t5_win_tick_sec", to_int(sh0, stn0, su0), 7);
        step(0, 1, 0, 0);
        ticks(7);
        step(1, 0, 1, 0);
        check("t5_pause_tick_sec", to_int(sh0, stn0, su0), 8);
        check("t5_pause_tick_state", int'(st0), 2);
        step(0, 0, 0, 0);

        // Asynchronous reset between edges
        step(0, 0, 1, 0);
        ticks(1);
        @(negedge clk);
        #2;
        clr = 1'b1;
        #1;
        check("t6_state", int'(st0), 0);
        check("t6_sec", to_int(sh0, stn0, su0), 0);
        check("t6_best", to_int(bh0, bt0, bu0), 999);
        check("t6_bv", int'(bv0), 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
